// File: rtl/famicom_reader.sv
// famicom_reader
//   Initiator for the Famicom/NES serial controller protocol. Drives latch
//   and pulse to a physical pad, shifts in its 8 serial bits and publishes
//   them as an active-high button byte with a one-cycle valid strobe.
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   automatic polling enable
//   poll_req   in   single-cycle request for an immediate poll
//   joy_data   in   serial data from the pad (active-low, asynchronous)
//   joy_latch  out  latch to pad (registered)
//   joy_pulse  out  clock to pad (registered)
//   buttons    out  {Right,Left,Down,Up,Start,Select,B,A}, 1 = pressed
//   valid      out  one-cycle strobe when buttons updates
//   busy       out  high while a poll is in progress
module famicom_reader #(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic       joy_data,
  output logic       joy_latch,
  output logic       joy_pulse,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int PH_W = $clog2(2 * HALF_CYC);
  localparam int PC_W = $clog2(POLL_CYC);

  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * HALF_CYC - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_CYC - 1);
  localparam logic [PC_W-1:0] POLL_LAST  = PC_W'(POLL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PC_W-1:0]   poll_q, poll_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        buttons_q, buttons_d;
  logic [1:0]        sync_q, sync_d;
  logic              joy_latch_q, joy_latch_d;
  logic              joy_pulse_q, joy_pulse_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              start_s;
  logic              data_sync_s;

  assign data_sync_s = sync_q[1];

  // Next-state logic: poll scheduling, phase timing, bit capture and the
  // registered-output values derived from the upcoming state.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    poll_d    = poll_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    start_s   = 1'b0;
    sync_d    = {sync_q[0], joy_data};

    case (state_q)
      S_IDLE: begin
        // A request and a counter wrap in the same cycle collapse into one poll.
        if (poll_req) begin
          start_s = 1'b1;
          poll_d  = '0;
        end else if (enable) begin
          if (poll_q == POLL_LAST) begin
            start_s = 1'b1;
            poll_d  = '0;
          end else begin
            poll_d = poll_q + PC_W'(1);
          end
        end else begin
          poll_d = poll_q;
        end
        if (start_s) begin
          state_d = S_LATCH;
          phase_d = '0;
          shift_d = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = S_LOW;
          phase_d = '0;
          idx_d   = 3'd0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_LOW: begin
        // Bit is taken at the end of the low half, just before the next pulse.
        if (phase_q == HALF_LAST) begin
          shift_d[idx_q] = ~data_sync_s;
          phase_d        = '0;
          if (idx_q == 3'd7) begin
            state_d   = S_DONE;
            buttons_d = shift_d;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_q == HALF_LAST) begin
          state_d = S_LOW;
          phase_d = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    joy_latch_d = (state_d == S_LATCH);
    joy_pulse_d = (state_d == S_HIGH);
    valid_d     = (state_d == S_DONE);
    busy_d      = (state_d == S_LATCH) || (state_d == S_LOW) || (state_d == S_HIGH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      poll_q      <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      buttons_q   <= 8'h00;
      sync_q      <= 2'b11;
      joy_latch_q <= 1'b0;
      joy_pulse_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      poll_q      <= poll_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      sync_q      <= sync_d;
      joy_latch_q <= joy_latch_d;
      joy_pulse_q <= joy_pulse_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign joy_latch = joy_latch_q;
  assign joy_pulse = joy_pulse_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_famicom_reader.sv
module tb_famicom_reader;

  localparam int H = 4;
  localparam int P = 200;
  localparam int T_DONE = 17 * H + 1;

  logic       clk_sys;
  logic       reset;
  logic       enable;
  logic       poll_req;
  logic       joy_data;
  logic       joy_latch;
  logic       joy_pulse;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  famicom_reader #(.HALF_CYC(H), .POLL_CYC(P)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .enable    (enable),
    .poll_req  (poll_req),
    .joy_data  (joy_data),
    .joy_latch (joy_latch),
    .joy_pulse (joy_pulse),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model: position within a poll (-1 when idle), idle poll
  // counter, captured bits, published byte and the two-cycle data delay.
  int         m_t;
  int         m_cnt;
  logic [7:0] m_bits;
  logic [7:0] m_btn;
  logic       m_d1, m_d2;
  logic       e_latch, e_pulse, e_busy, e_valid;

  // Pad model and event counters.
  logic       pad_mode;
  logic [7:0] pad;
  int         pad_idx;
  logic       prev_pulse, prev_latch;
  int         n_valid, n_latch_rise, n_pulse_rise, n_latch_hi;

  typedef struct {
    logic [7:0] pad;
    logic [7:0] exp_btn;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model over one clock period using the inputs present just before the edge.
  task automatic model_eval();
    int   tn;
    int   bi;
    logic sync_now;
    sync_now = m_d2;
    if (reset) begin
      tn    = -1;
      m_cnt = 0;
      m_btn = 8'h00;
      m_d1  = 1'b1;
      m_d2  = 1'b1;
    end else begin
      if (m_t < 0) begin
        tn = -1;
        if (poll_req) begin
          tn = 1;
          m_cnt = 0;
        end else if (enable) begin
          if (m_cnt == P - 1) begin
            tn = 1;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
      end else begin
        if (m_t >= 3 * H && ((m_t - 3 * H) % (2 * H)) == 0) begin
          bi = (m_t - 3 * H) / (2 * H);
          if (bi < 8) m_bits[bi[2:0]] = ~sync_now;
        end
        tn = (m_t == T_DONE) ? -1 : m_t + 1;
      end
      m_d2 = m_d1;
      m_d1 = joy_data;
      if (tn == T_DONE) m_btn = m_bits;
    end
    m_t     = tn;
    e_latch = (tn >= 1) && (tn <= 2 * H);
    e_pulse = (tn >= 3 * H + 1) && (tn <= 17 * H) && (((tn - 3 * H - 1) % (2 * H)) < H);
    e_busy  = (tn >= 1) && (tn <= 17 * H);
    e_valid = (tn == T_DONE);
  endtask

  // One clock period; optionally flip joy_data part-way through it.
  task automatic step(input int toggle_at);
    if (toggle_at > 0) begin
      #(toggle_at);
      joy_data = ~joy_data;
      #(8 - toggle_at);
    end else begin
      #8;
    end
    model_eval();
    @(posedge clk_sys);
    #1;
    check("latch", 32'(joy_latch), 32'(e_latch));
    check("pulse", 32'(joy_pulse), 32'(e_pulse));
    check("busy", 32'(busy), 32'(e_busy));
    check("valid", 32'(valid), 32'(e_valid));
    check("buttons", 32'(buttons), 32'(m_btn));
    if (joy_latch) pad_idx = 0;
    else if (joy_pulse && !prev_pulse) pad_idx++;
    if (joy_latch && !prev_latch) n_latch_rise++;
    if (joy_pulse && !prev_pulse) n_pulse_rise++;
    if (joy_latch) n_latch_hi++;
    if (valid) n_valid++;
    prev_pulse = joy_pulse;
    prev_latch = joy_latch;
    if (pad_mode) joy_data = (pad_idx < 8) ? pad[pad_idx[2:0]] : 1'b1;
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_latch_rise = 0;
    n_pulse_rise = 0;
    n_latch_hi = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0);
    reset = 1'b0;
  endtask

  // Request a poll and wait for its valid; returns cycles from request to valid.
  task automatic run_poll(output int lat);
    int n;
    poll_req = 1'b1;
    step(0);
    poll_req = 1'b0;
    n = 1;
    while (!valid && n < 120) begin
      step(0);
      n++;
    end
    lat = n;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    vecs[0] = '{pad: 8'hFF,        exp_btn: 8'h00};
    vecs[1] = '{pad: 8'b0110_1010, exp_btn: 8'b1001_0101};
    vecs[2] = '{pad: 8'h00,        exp_btn: 8'hFF};
    vecs[3] = '{pad: 8'b1111_1110, exp_btn: 8'h01};
    vecs[4] = '{pad: 8'b0111_1111, exp_btn: 8'h80};

    reset = 1'b1; enable = 1'b0; poll_req = 1'b0; joy_data = 1'b1;
    pad_mode = 1'b0; pad = 8'hFF; pad_idx = 0;
    prev_pulse = 1'b0; prev_latch = 1'b0;
    m_t = -1; m_cnt = 0; m_bits = 8'h00; m_btn = 8'h00; m_d1 = 1'b1; m_d2 = 1'b1;
    clear_counts();
    @(posedge clk_sys);
    #1;
    step(0);
    step(0);
    check("rst_latch", 32'(joy_latch), 32'd0);
    check("rst_pulse", 32'(joy_pulse), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Automatic polling with an idle line.
    enable = 1'b1;
    clear_counts();
    repeat (600) step(0);
    check("auto_valids", n_valid, 32'd2);
    check("auto_latch_cycles", n_latch_hi, 32'd16);
    check("auto_pulses", n_pulse_rise, 32'd14);
    check("auto_buttons", 32'(buttons), 32'h00);

    // Table of pad patterns via poll_req with polling disabled.
    enable = 1'b0;
    do_reset();
    pad_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pad = vecs[i].pad;
      pad_idx = 0;
      joy_data = pad[0];
      repeat (4) step(0);
      clear_counts();
      run_poll(lat);
      check("vec_latency", lat, T_DONE);
      check("vec_buttons", 32'(buttons), 32'(vecs[i].exp_btn));
      repeat (10) step(0);
      check("vec_single_valid", n_valid, 32'd1);
    end

    // Second request while busy is dropped; counter stays put with enable low.
    pad = 8'b1010_0101;
    pad_idx = 0;
    joy_data = pad[0];
    step(0);
    clear_counts();
    poll_req = 1'b1;
    step(0);
    poll_req = 1'b0;
    repeat (19) step(0);
    poll_req = 1'b1;
    step(0);
    poll_req = 1'b0;
    repeat (300) step(0);
    check("busy_req_latches", n_latch_rise, 32'd1);
    check("busy_req_valids", n_valid, 32'd1);
    check("busy_req_buttons", 32'(buttons), 32'h5A);

    // Counter wrap and poll_req in the same cycle.
    pad_mode = 1'b0;
    joy_data = 1'b1;
    do_reset();
    enable = 1'b1;
    repeat (199) step(0);
    clear_counts();
    poll_req = 1'b1;
    step(0);
    poll_req = 1'b0;
    check("simul_latch_now", 32'(joy_latch), 32'd1);
    repeat (150) step(0);
    check("simul_latches", n_latch_rise, 32'd1);
    check("simul_valids", n_valid, 32'd1);

    // Reset in the high phase of bit 3 after a non-zero result.
    enable = 1'b0;
    pad_mode = 1'b1;
    pad = 8'h0F;
    pad_idx = 0;
    joy_data = pad[0];
    step(0);
    run_poll(lat);
    check("pre_reset_buttons", 32'(buttons), 32'hF0);
    step(0);
    enable = 1'b1;
    poll_req = 1'b1;
    step(0);
    poll_req = 1'b0;
    repeat (37) step(0);
    check("bit3_high", 32'(joy_pulse), 32'd1);
    clear_counts();
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    check("midreset_latch", 32'(joy_latch), 32'd0);
    check("midreset_pulse", 32'(joy_pulse), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_buttons", 32'(buttons), 32'h00);
    check("midreset_valid", 32'(valid), 32'd0);
    n = 0;
    while (!joy_latch && n < 400) begin
      step(0);
      n++;
    end
    check("restart_delay", n, 32'd200);
    check("midreset_no_valid", n_valid, 32'd0);
    repeat (80) step(0);

    // Randomised traffic with asynchronous data edges.
    pad_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom % 8) != 0;
      poll_req = ($urandom % 64) == 0;
      reset    = ($urandom % 1500) == 0;
      joy_data = $urandom % 2 == 1;
      if ($urandom % 3 == 0) step(int'($urandom_range(1, 7)));
      else step(0);
    end
    reset = 1'b0;
    poll_req = 1'b0;
    step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
